// File: rtl/multiplicador_secuencial.sv
// ----------------------------------------------------------------------------
// multiplicador_secuencial
//
// Sequential shift-add multiplier for the ALU datapath. One operation is in
// flight at a time; a request is accepted only while the FSM is idle. Signed
// operands are handled by multiplying magnitudes and negating the 2*WIDTH
// magnitude at the end when the operand signs differ.
//
// Ports:
//   CLK     in   1        system clock, rising edge
//   RST_N   in   1        asynchronous active-low reset
//   START   in   1        request, sampled only in IDLE
//   SIGNED  in   1        1 = two's-complement operands, sampled with START
//   A       in   WIDTH    multiplicand, sampled with START
//   B       in   WIDTH    multiplier, sampled with START
//   BUSY    out  1        high while iterating (CALC state)
//   DONE    out  1        one-cycle pulse, results valid
//   P       out  2*WIDTH  full product
//   M       out  WIDTH    truncated product P[WIDTH-1:0]
//   OF      out  1        product does not fit in WIDTH bits for the mode
//
// Timing: START sampled at edge k gives DONE high in the cycle after edge
// k+WIDTH+1, so one result every WIDTH+2 cycles when START is re-asserted
// during the DONE cycle.
// ----------------------------------------------------------------------------
module multiplicador_secuencial #(
    parameter int WIDTH = 6,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 SIGNED,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   P,
    output logic [WIDTH-1:0]     M,
    output logic                 OF
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]           state;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     count;
    logic                 neg;
    logic                 mode_signed;
    logic                 done_q;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       upper_sum;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH:0]       sign_field;
    logic                 of_calc;

    // Operand magnitudes. The magnitude of the most negative value is
    // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number, so the
    // plain two's-complement negation is exact for every input.
    always_comb begin
        a_mag = A;
        b_mag = B;
        if (SIGNED && A[WIDTH-1]) begin
            a_mag = -A;
        end
        if (SIGNED && B[WIDTH-1]) begin
            b_mag = -B;
        end
    end

    // One shift-add step. The multiplier lives in the low half of the
    // accumulator and is consumed from bit 0; the multiplicand is added into
    // the upper half with its carry kept, and the carry becomes the new MSB
    // after the right shift.
    always_comb begin
        upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
        acc_next = {upper_sum, acc[WIDTH-1:1]};
    end

    // Final product and overflow. In signed mode the result fits only when
    // the upper half plus the truncated sign bit are a pure sign extension.
    always_comb begin
        product = acc;
        if (neg) begin
            product = -acc;
        end
        sign_field = product[2*WIDTH-1:WIDTH-1];
        if (mode_signed) begin
            of_calc = !((sign_field == '0) || (sign_field == '1));
        end else begin
            of_calc = |product[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM and datapath registers. DONE and the result registers are
    // written on the edge that leaves FIN, so the pulse coincides with the
    // first cycle back in IDLE and a new START can be accepted right then.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            mcand       <= '0;
            acc         <= '0;
            count       <= '0;
            neg         <= 1'b0;
            mode_signed <= 1'b0;
            done_q      <= 1'b0;
            P           <= '0;
            M           <= '0;
            OF          <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        mcand       <= a_mag;
                        acc         <= {{WIDTH{1'b0}}, b_mag};
                        neg         <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
                        mode_signed <= SIGNED;
                        count       <= '0;
                        state       <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc   <= acc_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST_ITER) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    P      <= product;
                    M      <= product[WIDTH-1:0];
                    OF     <= of_calc;
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY = (state == ST_CALC);
    assign DONE = done_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// ----------------------------------------------------------------------------
// tb_multiplicador_secuencial
//
// Directed vectors with hand-computed products for WIDTH=6, followed by a
// full sweep of both modes against an integer-arithmetic reference, plus the
// ignored-request and mid-operation reset scenarios. Inputs are driven and
// outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_multiplicador_secuencial;

    localparam int WIDTH = 6;
    localparam int LAT   = WIDTH + 2;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               sgn;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   m;
    logic               of;

    int checks = 0;
    int errors = 0;

    multiplicador_secuencial #(.WIDTH(WIDTH)) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .START  (start),
        .SIGNED (sgn),
        .A      (a),
        .B      (b),
        .BUSY   (busy),
        .DONE   (done),
        .P      (p),
        .M      (m),
        .OF     (of)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports a mismatch
    task automatic check_output(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Issue one request at the current falling edge and wait for DONE.
    // lat is the number of falling edges until DONE, or -1 on timeout.
    task automatic apply_stimulus(input logic s, input logic [WIDTH-1:0] av,
                                  input logic [WIDTH-1:0] bv, output int lat,
                                  output logic busy1);
        bit seen;
        seen  = 0;
        lat   = 0;
        busy1 = 1'b0;
        start = 1'b1;
        sgn   = s;
        a     = av;
        b     = bv;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (lat == 1) busy1 = busy;
            if (done) seen = 1;
        end
        if (!seen) lat = -1;
    endtask

    typedef struct {
        logic             s;
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        int               ep;
        int               em;
        int               eof;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat;
        logic busy1;
        int dones;

        // Hand-computed directed vectors
        vecs.push_back('{1'b0, 6'd7,  6'd9,  63,    63, 0});
        vecs.push_back('{1'b0, 6'd8,  6'd8,  64,    0,  1});
        vecs.push_back('{1'b0, 6'd63, 6'd63, 3969,  1,  1});
        vecs.push_back('{1'b1, 6'd61, 6'd5,  'hFF1, 49, 0});
        vecs.push_back('{1'b1, 6'd32, 6'd63, 'h020, 32, 1});
        vecs.push_back('{1'b1, 6'd32, 6'd1,  'hFE0, 32, 0});
        vecs.push_back('{1'b1, 6'd31, 6'd31, 'h3C1, 1,  1});
        vecs.push_back('{1'b0, 6'd0,  6'd45, 0,     0,  0});
        vecs.push_back('{1'b1, 6'd0,  6'd63, 0,     0,  0});

        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_p",    int'(p),    0);
        check_output("rst_m",    int'(m),    0);
        check_output("rst_of",   int'(of),   0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, with DONE checked to be a single-cycle pulse
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].s, vecs[i].av, vecs[i].bv, lat, busy1);
            check_output($sformatf("dir%0d_lat", i),  lat, LAT);
            check_output($sformatf("dir%0d_busy", i), int'(busy1), 1);
            check_output($sformatf("dir%0d_excl", i), int'(busy & done), 0);
            check_output($sformatf("dir%0d_p", i),    int'(p),  vecs[i].ep);
            check_output($sformatf("dir%0d_m", i),    int'(m),  vecs[i].em);
            check_output($sformatf("dir%0d_of", i),   int'(of), vecs[i].eof);
            @(negedge clk);
            check_output($sformatf("dir%0d_pulse", i), int'(done), 0);
        end

        // Full sweep, back-to-back: each request issued in the DONE cycle
        for (int s = 0; s < 2; s++) begin
            for (int ai = 0; ai < 64; ai++) begin
                for (int bi = 0; bi < 64; bi++) begin
                    int sa, sb, prod, eof;
                    logic [2*WIDTH-1:0] ep;
                    sa = (s == 1 && ai >= 32) ? ai - 64 : ai;
                    sb = (s == 1 && bi >= 32) ? bi - 64 : bi;
                    prod = sa * sb;
                    ep = 12'(prod);
                    if (s == 1) eof = (prod > 31 || prod < -32) ? 1 : 0;
                    else        eof = (prod > 63) ? 1 : 0;
                    apply_stimulus(s[0], 6'(ai), 6'(bi), lat, busy1);
                    check_output($sformatf("sw_s%0d_a%0d_b%0d_lat", s, ai, bi), lat, LAT);
                    check_output($sformatf("sw_s%0d_a%0d_b%0d_p", s, ai, bi), int'(p), int'(ep));
                    check_output($sformatf("sw_s%0d_a%0d_b%0d_m", s, ai, bi), int'(m), int'(ep[WIDTH-1:0]));
                    check_output($sformatf("sw_s%0d_a%0d_b%0d_of", s, ai, bi), int'(of), eof);
                end
            end
        end
        @(negedge clk);
        @(negedge clk);

        // Request during CALC is ignored; P holds the previous result meanwhile
        start = 1'b1;
        sgn   = 1'b0;
        a     = 6'd5;
        b     = 6'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_output("ign_busy", int'(busy), 1);
        check_output("ign_p_hold", int'(p), 1);
        start = 1'b1;
        a     = 6'd2;
        b     = 6'd2;
        @(negedge clk);
        start = 1'b0;
        a     = 6'd0;
        b     = 6'd0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                check_output("ign_p", int'(p), 25);
            end
        end
        check_output("ign_dones", dones, 1);
        check_output("ign_p_final", int'(p), 25);

        // Asynchronous reset three cycles into CALC
        start = 1'b1;
        a     = 6'd9;
        b     = 6'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rstmid_busy_before", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("rstmid_p",    int'(p),    0);
        check_output("rstmid_busy", int'(busy), 0);
        check_output("rstmid_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_output("rstmid_no_done", dones, 0);

        // Fresh request after reset release
        apply_stimulus(1'b0, 6'd9, 6'd9, lat, busy1);
        check_output("post_lat", lat, LAT);
        check_output("post_p",   int'(p),  81);
        check_output("post_m",   int'(m),  17);
        check_output("post_of",  int'(of), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
